// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a
//   valid/ready handshake. It can be built with a 2-entry skid buffer
//   (SKID=1, in_ready decoded from registered state only) or as a 1-entry
//   register (SKID=0, in_ready combinational from out_ready).
//   A synchronous flush discards every held entry. The control field reads
//   as zero whenever no valid entry is held, so a bubble can never raise a
//   spurious RegWrite or MemWrite downstream.
//
// Parameters
//   DATA_W  payload width (>=1)
//   CTRL_W  control-field width (>=1)
//   SKID    1: 2-entry skid buffer, 0: single register
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous discard of all held entries
//   in_valid   upstream presents an entry
//   in_ready   stage accepts an entry this cycle
//   in_ctrl    upstream control bits
//   in_data    upstream payload
//   out_valid  downstream entry valid
//   out_ready  downstream accepts (0 = stall)
//   out_ctrl   control bits, all-zero when out_valid=0
//   out_data   payload, holds its last value when out_valid=0
//   occupancy  number of entries held (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding equals the number of entries held, so occupancy is the state.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              push, pop;
  logic              load_main_in, load_main_skid, load_skid;

  assign out_valid = (state != S_EMPTY);
  assign occupancy = state;
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;

  generate
    if (SKID != 0) begin : g_skid
      // Depends only on the state register: no combinational path from
      // out_ready back to in_ready, which breaks long ready chains.
      assign in_ready = (state != S_TWO);
    end else begin : g_noskid
      // Accept when empty, or when the held entry leaves this same cycle.
      assign in_ready = (state == S_EMPTY) | out_ready;
    end
  endgenerate

  // A flushed input is never counted as transferred; a flushed output
  // transfer still completes downstream (pop is not gated).
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (push) begin
            state_nxt    = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          unique case ({push, pop})
            2'b10: begin
              // Only reachable with SKID=1: downstream stalled, park in skid.
              state_nxt = S_TWO;
              load_skid = 1'b1;
            end
            2'b11:   load_main_in = 1'b1;
            2'b01:   state_nxt    = S_EMPTY;
            default: ;
          endcase
        end
        S_TWO: begin
          // in_ready is low here, so no input can arrive.
          if (pop) begin
            state_nxt      = S_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the payload registers are reset because out_data must read zero
  // after reset; a plain datapath register would otherwise be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

endmodule
